mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_sched_pkg.sv | 6 +
 rtl/seq_mul_core.sv | 41 ++++
 rtl/mult_scheduler.sv | 82 ++++++++
 tb/tb_mult_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared FSM state type and default sizing for the multiplier scheduler.
package mult_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF = 4;
endpackage

// File: rtl/seq_mul_core.sv
// seq_mul_core: shift-add multiplier datapath, one partial-product step per step_i cycle.
module seq_mul_core
  import mult_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   multiplicand_i,
  input  logic [W-1:0]   multiplier_i,
  output logic [2*W-1:0] acc_o,
  output logic           last_o
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W:0]     upper;
  // The carry out of the add lands in the top bit, so the shifted acc never overflows.
  always_comb begin
    upper   = acc_q[0] ? {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q} : {1'b0, acc_q[2*W-1:W]};
    mcand_d = load_i ? multiplicand_i : mcand_q;
    acc_d   = load_i ? {{W{1'b0}}, multiplier_i} : step_i ? {upper, acc_q[W-1:1]} : acc_q;
    count_d = load_i ? '0 : step_i ? count_q + CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
  assign acc_o  = acc_q;
  assign last_o = count_q == CW'(W - 1);
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin arbiter sharing one shift-add multiplier among NREQ requesters.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W = W_DEF,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*W-1:0] req_multiplicand,
  input  logic [NREQ*W-1:0] req_multiplier,
  output logic [NREQ-1:0]  req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_id,
  output logic [2*W-1:0]   res_product,
  output logic             busy
);
  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d, id_q, id_d, win;
  logic [NREQ-1:0] masked, pick, grant;
  logic [W-1:0]    mcand_sel, mplier_sel;
  logic            load, step, last;
  logic [2*W-1:0]  acc;
  // Requests at or above rr_ptr take priority; otherwise wrap to the lowest set bit.
  always_comb begin
    masked     = req_valid & ({NREQ{1'b1}} << rr_ptr_q);
    pick       = |masked ? masked : req_valid;
    grant      = pick & (~pick + NREQ'(1));
    win        = IW'($countones(grant - NREQ'(1)));
    mcand_sel  = W'(req_multiplicand >> (32'(win) * W));
    mplier_sel = W'(req_multiplier >> (32'(win) * W));
  end
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        req_ready = reset_n ? grant : '0;
        load      = |req_valid;
        state_d   = |req_valid ? RUN : IDLE;
      end
      RUN: begin
        step    = 1'b1;
        state_d = last ? DONE : RUN;
      end
      DONE:    state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    rr_ptr_d = load ? (win == IW'(NREQ - 1) ? '0 : win + IW'(1)) : rr_ptr_q;
    id_d     = load ? win : id_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
    end
  end
  seq_mul_core #(.W(W)) u_core (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_i        (load),
    .step_i        (step),
    .multiplicand_i(mcand_sel),
    .multiplier_i  (mplier_sel),
    .acc_o         (acc),
    .last_o        (last)
  );
  assign busy        = state_q != IDLE;
  assign res_valid   = state_q == DONE;
  assign res_product = acc;
  assign res_id      = id_q;
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: randomized and directed checks against a round-robin/product reference model.
module tb_mult_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] mcand = '0, mplier = '0;
  logic [3:0]  req_ready;
  logic        res_valid, res_ready = 1'b1, busy;
  logic [1:0]  res_id;
  logic [7:0]  res_product;
  int passed = 0, total = 0;
  int model_rr = 0;
  int ma[4], mb[4];

  mult_scheduler dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_multiplicand(mcand), .req_multiplier(mplier), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_product(res_product), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int idx = (model_rr + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    ma[i] = a;
    mb[i] = b;
    mcand[i*4 +: 4] = 4'(a);
    mplier[i*4 +: 4] = 4'(b);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_rr = 0;
  endtask

  // Presents v, accepts on the next edge and waits for the result; leaves the result unacknowledged.
  task automatic do_op(input logic [3:0] v, output logic [3:0] rdy, output int lat,
                       output logic [1:0] id, output logic [7:0] prod);
    req_valid = v;
    #1;
    rdy = req_ready;
    @(posedge clk); #1;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    id = res_id;
    prod = res_product;
  endtask

  task automatic check_op(input string name, input int e, input logic [3:0] rdy, input int lat,
                          input logic [1:0] id, input logic [7:0] prod);
    logic [3:0] eg;
    logic [7:0] ep;
    eg = 4'b0001 << e;
    ep = 8'(ma[e] * mb[e]);
    total++;
    if (rdy !== eg) $display("FAIL %s grant: got %b expected %b", name, rdy, eg); else passed++;
    total++;
    if (lat !== 4) $display("FAIL %s latency: got %0d expected 4", name, lat); else passed++;
    total++;
    if (id !== 2'(e)) $display("FAIL %s res_id: got %0d expected %0d", name, id, e); else passed++;
    total++;
    if (prod !== ep) $display("FAIL %s product: got %0d expected %0d", name, prod, ep); else passed++;
  endtask

  task automatic handshake(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s handshake: got valid=%b busy=%b expected 0 0", name, res_valid, busy);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_ops(i, 15, 15);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0000) $display("FAIL reset req_ready: got %b expected 0000", req_ready); else passed++;
    total++;
    if (res_valid !== 1'b0) $display("FAIL reset res_valid: got %b expected 0", res_valid); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
    total++;
    if (res_id !== 2'd0) $display("FAIL reset res_id: got %0d expected 0", res_id); else passed++;
    total++;
    if (res_product !== 8'd0) $display("FAIL reset res_product: got %0d expected 0", res_product); else passed++;
    apply_reset();
  endtask

  task automatic test_single();
    logic [3:0] rdy; int lat, e; logic [1:0] id; logic [7:0] prod;
    set_ops(0, 13, 11);
    e = model_pick(4'b0001);
    do_op(4'b0001, rdy, lat, id, prod);
    model_rr = (e + 1) % 4;
    check_op("single", e, rdy, lat, id, prod);
    total++;
    if (prod !== 8'd143) $display("FAIL single 13x11: got %0d expected 143", prod); else passed++;
    handshake("single");
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy; int lat, e; logic [1:0] id; logic [7:0] prod;
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) set_ops(i, i * 3 + 2, 13 - i * 2);
    for (int n = 0; n < 5; n++) begin
      e = model_pick(4'b1111);
      do_op(4'b1111, rdy, lat, id, prod);
      model_rr = (e + 1) % 4;
      check_op("round_robin", e, rdy, lat, id, prod);
      total++;
      if (id !== 2'(order[n])) $display("FAIL round_robin order: got %0d expected %0d", id, order[n]); else passed++;
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy; int lat, e; logic [1:0] id; logic [7:0] prod;
    res_ready = 1'b0;
    set_ops(2, 9, 14);
    e = model_pick(4'b0100);
    do_op(4'b0100, rdy, lat, id, prod);
    model_rr = (e + 1) % 4;
    check_op("backpressure", e, rdy, lat, id, prod);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (res_valid !== 1'b1 || res_product !== 8'd126 || res_id !== 2'd2 || req_ready !== 4'b0000)
        $display("FAIL backpressure hold: got valid=%b prod=%0d id=%0d ready=%b expected 1 126 2 0000",
                 res_valid, res_product, res_id, req_ready);
      else passed++;
    end
    handshake("backpressure");
  endtask

  task automatic test_boundaries();
    logic [3:0] rdy; int lat, e; logic [1:0] id; logic [7:0] prod;
    int av[4] = '{15, 0, 15, 1};
    int bv[4] = '{15, 15, 0, 1};
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ops(k, av[k], bv[k]);
      e = model_pick(4'b0001 << k);
      do_op(4'b0001 << k, rdy, lat, id, prod);
      model_rr = (e + 1) % 4;
      check_op("boundary", e, rdy, lat, id, prod);
      handshake("boundary");
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen = 0;
    set_ops(2, 5, 5);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL reset_mid_run: got busy=%b valid=%b expected 0 0", busy, res_valid);
    else passed++;
    reset_n = 1'b1;
    model_rr = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL reset_mid_run result: got res_valid=1 expected none"); else passed++;
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL reset_mid_run next grant: got %b expected 0001", req_ready); else passed++;
    req_valid = '0;
  endtask

  task automatic test_operand_change();
    int lat = 0;
    set_ops(1, 6, 7);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    set_ops(1, 2, 2);
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (res_product !== 8'd42 || res_id !== 2'd1)
      $display("FAIL operand_change: got prod=%0d id=%0d expected 42 1", res_product, res_id);
    else passed++;
    model_rr = 2;
    handshake("operand_change");
  endtask

  task automatic test_random();
    logic [3:0] rdy, v; int lat, e; logic [1:0] id; logic [7:0] prod;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) set_ops(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      v = 4'($urandom_range(1, 15));
      res_ready = 1'b0;
      e = model_pick(v);
      do_op(v, rdy, lat, id, prod);
      model_rr = (e + 1) % 4;
      check_op("random", e, rdy, lat, id, prod);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      handshake("random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundaries();
    test_reset_mid_run();
    test_operand_change();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
